// File: rtl/counter_pkg.sv
// Shared types and code tables for the ring/Johnson counter checker.
package counter_pkg;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned PHASE_W   = 3;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned JOHNSON_N = 8;
  localparam int unsigned RING_N    = 4;

  // Entry i is the code for phase/position i.
  localparam logic [JOHNSON_N-1:0][CODE_W-1:0] JOHNSON_CODE = {
    4'b1000, 4'b1100, 4'b1110, 4'b1111,
    4'b0111, 4'b0011, 4'b0001, 4'b0000
  };

  localparam logic [RING_N-1:0][CODE_W-1:0] RING_CODE = {
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  typedef enum logic [1:0] {
    SEARCH,
    LOCKED,
    FAULT
  } state_t;

endpackage

// File: rtl/code_decoder.sv
// Combinational decode of ring and Johnson codes into position plus legality.
module code_decoder
  import counter_pkg::*;
(
  input  logic [CODE_W-1:0]  qr,
  input  logic [CODE_W-1:0]  qj,
  output logic [PHASE_W-1:0] phase,
  output logic [IDX_W-1:0]   ring_idx,
  output logic               j_ok,
  output logic               r_ok
);

  always_comb begin
    phase    = '0;
    j_ok     = 1'b0;
    ring_idx = '0;
    r_ok     = 1'b0;
    for (int unsigned i = 0; i < JOHNSON_N; i++) begin
      if (qj == JOHNSON_CODE[i]) begin
        phase = PHASE_W'(i);
        j_ok  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < RING_N; i++) begin
      if (qr == RING_CODE[i]) begin
        ring_idx = IDX_W'(i);
        r_ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Checks a ring and a Johnson counter for lock-step advance; locks after
// LOCK_N consecutive legal steps and counts faults and Johnson wraps.
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned LOCK_N = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CODE_W-1:0]  qr,
  input  logic [CODE_W-1:0]  qj,
  input  logic               clr,
  output logic [PHASE_W-1:0] phase,
  output logic [IDX_W-1:0]   ring_idx,
  output logic               code_ok,
  output logic               locked,
  output logic               err,
  output logic [W-1:0]       err_cnt,
  output logic [W-1:0]       wrap_cnt
);

  localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

  state_t             state, state_n;
  logic [RUN_W-1:0]   run, run_n, run_inc;
  logic               has_pred;
  logic [PHASE_W-1:0] dec_phase;
  logic [IDX_W-1:0]   dec_idx;
  logic               j_ok, r_ok;
  logic               step_ok, wrap_step;
  logic               fault_ev, wrap_ev;

  code_decoder u_dec (
    .qr       (qr),
    .qj       (qj),
    .phase    (dec_phase),
    .ring_idx (dec_idx),
    .j_ok     (j_ok),
    .r_ok     (r_ok)
  );

  // phase/ring_idx hold the last legal sample, so they are the predecessor.
  always_comb begin
    step_ok   = has_pred && j_ok && r_ok &&
                (dec_phase == PHASE_W'(phase + 1'b1)) &&
                (dec_idx == IDX_W'(ring_idx + 1'b1));
    wrap_step = step_ok && (phase == '1) && (dec_phase == '0);
    run_inc   = run + 1'b1;
  end

  always_comb begin
    state_n  = state;
    run_n    = run;
    fault_ev = 1'b0;
    wrap_ev  = 1'b0;
    case (state)
      SEARCH: begin
        if (has_pred) begin
          if (!step_ok) begin
            run_n = '0;
          end else if (run_inc == RUN_W'(LOCK_N)) begin
            state_n = LOCKED;
            run_n   = '0;
          end else begin
            run_n = run_inc;
          end
        end
      end
      LOCKED: begin
        if (!step_ok) begin
          state_n  = FAULT;
          fault_ev = 1'b1;
        end else begin
          wrap_ev = wrap_step;
        end
      end
      FAULT: begin
        state_n = SEARCH;
        run_n   = '0;
      end
      default: begin
        state_n = SEARCH;
        run_n   = '0;
      end
    endcase
  end

  // The sample taken on the edge leaving FAULT becomes the new baseline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      run      <= '0;
      has_pred <= 1'b0;
      phase    <= '0;
      ring_idx <= '0;
      code_ok  <= 1'b0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      has_pred <= (state_n != FAULT);
      code_ok  <= j_ok & r_ok;
      if (j_ok) phase    <= dec_phase;
      if (r_ok) ring_idx <= dec_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (clr) begin
      err      <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      if (fault_ev) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
      if (wrap_ev) wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule
